// File: rtl/vp_lvp_pkg.sv
// Shared types and address/confidence helpers for the last-value predictor.
package vp_lvp_pkg;

    localparam int unsigned LVP_TAG_W   = 8;
    localparam int unsigned LVP_VALUE_W = 32;
    localparam int unsigned LVP_CONF_W  = 3;

    // Entry layout at the default configuration; the core derives its own from its parameters.
    typedef struct packed {
        logic                   valid;
        logic [LVP_TAG_W-1:0]   tag;
        logic [LVP_VALUE_W-1:0] value;
        logic [LVP_CONF_W-1:0]  conf;
    } lvp_entry_t;

    function automatic logic [31:0] get_index(input logic [31:1] pc, input int unsigned idx_w);
        logic [31:0] pc_w;
        pc_w = {1'b0, pc};
        return pc_w & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] get_tag(input logic [31:1] pc, input int unsigned idx_w,
                                            input int unsigned tag_w);
        logic [31:0] pc_w;
        pc_w = {1'b0, pc};
        return (pc_w >> idx_w) & ((32'd1 << tag_w) - 32'd1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] conf, input int unsigned conf_w);
        logic [31:0] max_v;
        max_v = (32'd1 << conf_w) - 32'd1;
        return (conf >= max_v) ? max_v : conf + 32'd1;
    endfunction

endpackage

// File: rtl/vp_lvp_fb_arb.sv
// Same-cycle feedback collision masking: a lane writes only if no higher lane targets its index.
module vp_lvp_fb_arb
    import vp_lvp_pkg::*;
#(
    parameter int unsigned P_NUM_PRED = 2,
    parameter int unsigned IDX_W      = 8
) (
    input  logic [P_NUM_PRED-1:0][IDX_W-1:0] idx_i,
    input  logic [P_NUM_PRED-1:0]            valid_i,
    output logic [P_NUM_PRED-1:0]            we_c
);

    always_comb begin
        we_c = valid_i;
        for (int i = 0; i < P_NUM_PRED; i++) begin
            for (int j = i + 1; j < P_NUM_PRED; j++) begin
                if (valid_i[j] && (idx_i[j] == idx_i[i])) begin
                    we_c[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/vp_lvp_core.sv
// Parametrised tagged last-value predictor: flop table, D/E1 prediction pipeline, feedback training.
module vp_lvp_core
    import vp_lvp_pkg::*;
#(
    parameter int unsigned P_NUM_PRED    = 2,
    parameter int unsigned P_ENTRIES     = 256,
    parameter int unsigned P_TAG_WIDTH   = 8,
    parameter int unsigned P_VALUE_WIDTH = 32,
    parameter int unsigned P_CONF_WIDTH  = 3,
    parameter int unsigned P_CONF_THRES  = 7
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [P_NUM_PRED-1:0][31:1]                fw_pc_aln_i,
    input  logic [P_NUM_PRED-1:0]                      fw_valid_aln_i,
    input  logic                                       flush_i,
    output logic [P_NUM_PRED-1:0][P_CONF_WIDTH-1:0]    pred_conf_d_o,
    output logic [P_NUM_PRED-1:0]                      pred_confident_d_o,
    output logic [P_NUM_PRED-1:0]                      pred_valid_d_o,
    output logic [P_NUM_PRED-1:0][P_VALUE_WIDTH-1:0]   pred_result_e1_o,
    output logic [P_NUM_PRED-1:0]                      pred_valid_e1_o,
    input  logic [P_NUM_PRED-1:0][31:1]                fb_pc_i,
    input  logic [P_NUM_PRED-1:0][P_VALUE_WIDTH-1:0]   fb_actual_i,
    input  logic [P_NUM_PRED-1:0]                      fb_valid_i
);

    localparam int unsigned IDX_W = $clog2(P_ENTRIES);
    localparam logic [P_CONF_WIDTH-1:0] CONF_THRES = P_CONF_WIDTH'(P_CONF_THRES);

    typedef struct packed {
        logic                     valid;
        logic [P_TAG_WIDTH-1:0]   tag;
        logic [P_VALUE_WIDTH-1:0] value;
        logic [P_CONF_WIDTH-1:0]  conf;
    } entry_t;

    entry_t tbl_q [P_ENTRIES];

    logic [P_NUM_PRED-1:0][IDX_W-1:0]         lk_idx;
    logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]   lk_tag;
    logic [P_NUM_PRED-1:0]                    lk_live;
    logic [P_NUM_PRED-1:0]                    lk_hit;
    entry_t                                   lk_ent [P_NUM_PRED];

    logic [P_NUM_PRED-1:0][IDX_W-1:0]         fb_idx;
    logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]   fb_tag;
    logic [P_NUM_PRED-1:0]                    fb_we;
    entry_t                                   fb_new [P_NUM_PRED];

    logic [P_NUM_PRED-1:0]                    valid_d_q;
    logic [P_NUM_PRED-1:0][P_CONF_WIDTH-1:0]  conf_d_q;
    logic [P_NUM_PRED-1:0]                    confident_d_q;
    logic [P_NUM_PRED-1:0][P_VALUE_WIDTH-1:0] value_d_q;
    logic [P_NUM_PRED-1:0]                    valid_e1_q;
    logic [P_NUM_PRED-1:0][P_VALUE_WIDTH-1:0] result_e1_q;

    // Lookup read; a flushed lookup is treated exactly like an invalid one.
    always_comb begin
        lk_live = fw_valid_aln_i & ~{P_NUM_PRED{flush_i}};
        for (int i = 0; i < P_NUM_PRED; i++) begin
            lk_idx[i] = IDX_W'(get_index(fw_pc_aln_i[i], IDX_W));
            lk_tag[i] = P_TAG_WIDTH'(get_tag(fw_pc_aln_i[i], IDX_W, P_TAG_WIDTH));
            lk_ent[i] = tbl_q[lk_idx[i]];
            lk_hit[i] = lk_live[i] && lk_ent[i].valid && (lk_ent[i].tag == lk_tag[i]);
        end
    end

    // Per-lane next entry, computed from the pre-update table contents.
    always_comb begin
        for (int j = 0; j < P_NUM_PRED; j++) begin
            entry_t cur;
            fb_new[j] = '0;
            fb_idx[j] = IDX_W'(get_index(fb_pc_i[j], IDX_W));
            fb_tag[j] = P_TAG_WIDTH'(get_tag(fb_pc_i[j], IDX_W, P_TAG_WIDTH));
            cur       = tbl_q[fb_idx[j]];
            fb_new[j].valid = 1'b1;
            fb_new[j].tag   = fb_tag[j];
            if (cur.valid && (cur.tag == fb_tag[j]) && (cur.value == fb_actual_i[j])) begin
                fb_new[j].value = cur.value;
                fb_new[j].conf  = P_CONF_WIDTH'(sat_inc(32'(cur.conf), P_CONF_WIDTH));
            end else begin
                fb_new[j].value = fb_actual_i[j];
                fb_new[j].conf  = '0;
            end
        end
    end

    vp_lvp_fb_arb #(
        .P_NUM_PRED (P_NUM_PRED),
        .IDX_W      (IDX_W)
    ) u_fb_arb (
        .idx_i   (fb_idx),
        .valid_i (fb_valid_i),
        .we_c    (fb_we)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int e = 0; e < P_ENTRIES; e++) begin
                tbl_q[e].valid <= 1'b0;
            end
            valid_d_q     <= '0;
            conf_d_q      <= '0;
            confident_d_q <= '0;
            value_d_q     <= '0;
            valid_e1_q    <= '0;
            result_e1_q   <= '0;
        end else begin
            for (int j = 0; j < P_NUM_PRED; j++) begin
                if (fb_we[j]) begin
                    tbl_q[fb_idx[j]] <= fb_new[j];
                end
            end
            for (int i = 0; i < P_NUM_PRED; i++) begin
                conf_d_q[i]      <= lk_hit[i] ? lk_ent[i].conf : '0;
                confident_d_q[i] <= lk_hit[i] && (lk_ent[i].conf >= CONF_THRES);
                value_d_q[i]     <= lk_hit[i] ? lk_ent[i].value : '0;
            end
            valid_d_q   <= lk_live;
            valid_e1_q  <= valid_d_q & ~{P_NUM_PRED{flush_i}};
            result_e1_q <= value_d_q;
        end
    end

    assign pred_valid_d_o     = valid_d_q;
    assign pred_conf_d_o      = conf_d_q;
    assign pred_confident_d_o = confident_d_q;
    assign pred_valid_e1_o    = valid_e1_q;
    assign pred_result_e1_o   = result_e1_q;

endmodule

// File: tb/tb_vp_lvp_core.sv
// Self-checking bench for vp_lvp_core: directed test-plan scenarios plus random traffic vs a table model.
module tb_vp_lvp_core;

    localparam int NP = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NP-1:0][31:1]  fw_pc;
    logic [NP-1:0]        fw_vld;
    logic                 flush;
    logic [NP-1:0][2:0]   conf_d;
    logic [NP-1:0]        cfd_d;
    logic [NP-1:0]        vld_d;
    logic [NP-1:0][31:0]  res_e1;
    logic [NP-1:0]        vld_e1;
    logic [NP-1:0][31:1]  fb_pc;
    logic [NP-1:0][31:0]  fb_act;
    logic [NP-1:0]        fb_vld;

    int n_checks = 0;
    int n_pass   = 0;

    vp_lvp_core dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .fw_pc_aln_i        (fw_pc),
        .fw_valid_aln_i     (fw_vld),
        .flush_i            (flush),
        .pred_conf_d_o      (conf_d),
        .pred_confident_d_o (cfd_d),
        .pred_valid_d_o     (vld_d),
        .pred_result_e1_o   (res_e1),
        .pred_valid_e1_o    (vld_e1),
        .fb_pc_i            (fb_pc),
        .fb_actual_i        (fb_act),
        .fb_valid_i         (fb_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: 256 direct-mapped entries, byte-address arithmetic.
    bit          m_valid [256];
    int unsigned m_tag   [256];
    logic [31:0] m_value [256];
    int unsigned m_conf  [256];

    bit          e_vld_d [NP];
    int unsigned e_conf  [NP];
    bit          e_cfd   [NP];
    logic [31:0] e_val_d [NP];
    bit          e_vld_e1[NP];
    logic [31:0] e_res   [NP];

    always begin
        int unsigned u_idx [NP];
        int unsigned u_tag [NP];
        logic [31:0] u_val [NP];
        int unsigned u_conf[NP];
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < 256; k++) m_valid[k] = 1'b0;
            for (int l = 0; l < NP; l++) begin
                e_vld_d[l] = 0; e_conf[l] = 0; e_cfd[l] = 0; e_val_d[l] = 0;
                e_vld_e1[l] = 0; e_res[l] = 0;
            end
        end else begin
            for (int l = 0; l < NP; l++) begin
                e_vld_e1[l] = e_vld_d[l] && !flush;
                e_res[l]    = e_val_d[l];
            end
            for (int l = 0; l < NP; l++) begin
                int unsigned a, idx, tg;
                bit live, hit;
                a    = {fw_pc[l], 1'b0};
                idx  = (a / 2) % 256;
                tg   = (a / 512) % 256;
                live = fw_vld[l] && !flush;
                hit  = live && m_valid[idx] && (m_tag[idx] == tg);
                e_vld_d[l] = live;
                e_conf[l]  = hit ? m_conf[idx] : 0;
                e_cfd[l]   = hit && (m_conf[idx] >= 7);
                e_val_d[l] = hit ? m_value[idx] : 32'h0;
            end
            for (int l = 0; l < NP; l++) begin
                int unsigned a;
                a = {fb_pc[l], 1'b0};
                u_idx[l] = (a / 2) % 256;
                u_tag[l] = (a / 512) % 256;
                if (m_valid[u_idx[l]] && m_tag[u_idx[l]] == u_tag[l] && m_value[u_idx[l]] == fb_act[l]) begin
                    u_val[l]  = fb_act[l];
                    u_conf[l] = (m_conf[u_idx[l]] == 7) ? 7 : m_conf[u_idx[l]] + 1;
                end else begin
                    u_val[l]  = fb_act[l];
                    u_conf[l] = 0;
                end
            end
            // Applied in lane order so the highest colliding lane is the one left standing.
            for (int l = 0; l < NP; l++) begin
                if (fb_vld[l]) begin
                    m_valid[u_idx[l]] = 1'b1;
                    m_tag[u_idx[l]]   = u_tag[l];
                    m_value[u_idx[l]] = u_val[l];
                    m_conf[u_idx[l]]  = u_conf[l];
                end
            end
        end
        @(negedge clk);
        for (int l = 0; l < NP; l++) begin
            chk($sformatf("m_vld_d[%0d]", l), 64'(vld_d[l]), 64'(e_vld_d[l]));
            chk($sformatf("m_conf_d[%0d]", l), 64'(conf_d[l]), 64'(e_conf[l]));
            chk($sformatf("m_cfd_d[%0d]", l), 64'(cfd_d[l]), 64'(e_cfd[l]));
            chk($sformatf("m_vld_e1[%0d]", l), 64'(vld_e1[l]), 64'(e_vld_e1[l]));
            chk($sformatf("m_res_e1[%0d]", l), 64'(res_e1[l]), 64'(e_res[l]));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        fw_vld = '0; fw_pc = '0; flush = 1'b0;
        fb_vld = '0; fb_pc = '0; fb_act = '0;
    endtask

    task automatic do_fb(input int lane, input logic [31:0] a, input logic [31:0] v);
        fb_vld[lane] = 1'b1; fb_pc[lane] = a[31:1]; fb_act[lane] = v;
        tick();
        fb_vld = '0;
    endtask

    task automatic do_lookup(input string nm, input int lane, input logic [31:0] a,
                             input logic [2:0] x_conf, input logic x_cfd, input logic [31:0] x_res);
        fw_vld[lane] = 1'b1; fw_pc[lane] = a[31:1];
        tick();
        fw_vld = '0;
        chk({nm, "_vld_d"}, 64'(vld_d), 64'(1 << lane));
        chk({nm, "_conf"},  64'(conf_d[lane]), 64'(x_conf));
        chk({nm, "_cfd"},   64'(cfd_d[lane]), 64'(x_cfd));
        tick();
        chk({nm, "_vld_e1"}, 64'(vld_e1), 64'(1 << lane));
        chk({nm, "_res"},    64'(res_e1[lane]), 64'(x_res));
    endtask

    localparam int unsigned POOL_N = 7;

    initial begin
        logic [31:0] pc_pool [POOL_N];
        logic [31:0] val_pool [4];
        logic [31:0] a;
        pc_pool  = '{32'h100, 32'h300, 32'h500, 32'h102, 32'h200, 32'h202, 32'h1100};
        val_pool = '{32'h1, 32'h2, 32'h3, 32'hDEADBEEF};

        rst_n = 1'b0;
        clear_inputs();
        tick();
        chk("rst_vld_d", 64'(vld_d), 64'h0);
        chk("rst_vld_e1", 64'(vld_e1), 64'h0);
        chk("rst_res", 64'(res_e1), 64'h0);
        tick();
        rst_n = 1'b1;

        do_lookup("cold", 0, 32'h100, 3'd0, 1'b0, 32'h0);

        for (int k = 0; k < 8; k++) do_fb(0, 32'h100, 32'hDEADBEEF);
        do_lookup("trained", 0, 32'h100, 3'd7, 1'b1, 32'hDEADBEEF);
        do_fb(0, 32'h100, 32'hDEADBEEF);
        do_lookup("saturated", 1, 32'h100, 3'd7, 1'b1, 32'hDEADBEEF);

        do_fb(1, 32'h100, 32'h1);
        do_lookup("mispredict", 0, 32'h100, 3'd0, 1'b0, 32'h1);

        fb_vld = 2'b11; fb_pc[0] = 31'h100; fb_pc[1] = 31'h100;
        fb_act[0] = 32'hA; fb_act[1] = 32'hB;
        tick();
        fb_vld = '0;
        do_lookup("collide", 1, 32'h200, 3'd0, 1'b0, 32'hB);
        // Both lanes hit-and-match from the same pre-state: one increment, not two.
        fb_vld = 2'b11; fb_act[0] = 32'hB; fb_act[1] = 32'hB;
        tick();
        fb_vld = '0;
        do_lookup("collide_eq", 0, 32'h200, 3'd1, 1'b0, 32'hB);

        do_fb(0, 32'h300, 32'h33);
        do_lookup("alias_old", 0, 32'h100, 3'd0, 1'b0, 32'h0);
        do_lookup("alias_new", 1, 32'h300, 3'd0, 1'b0, 32'h33);

        fw_vld[0] = 1'b1; fw_pc[0] = 31'h180;
        tick();
        fw_vld = '0;
        chk("flush_pre_vld_d", 64'(vld_d), 64'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_vld_e1", 64'(vld_e1), 64'h0);
        chk("flush_vld_d", 64'(vld_d), 64'h0);
        do_lookup("flush_keep", 0, 32'h300, 3'd0, 1'b0, 32'h33);

        fw_vld[0] = 1'b1; fw_pc[0] = 31'h180;
        tick();
        fw_vld = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_vld_d", 64'(vld_d), 64'h0);
        chk("mrst_vld_e1", 64'(vld_e1), 64'h0);
        chk("mrst_conf", 64'(conf_d), 64'h0);
        chk("mrst_res", 64'(res_e1), 64'h0);
        do_lookup("mrst_empty", 0, 32'h300, 3'd0, 1'b0, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            flush = ($urandom_range(0, 15) == 0);
            for (int l = 0; l < NP; l++) begin
                fw_vld[l] = 1'($urandom_range(0, 1));
                a = pc_pool[$urandom_range(0, POOL_N - 1)];
                fw_pc[l] = a[31:1];
                fb_vld[l] = ($urandom_range(0, 2) != 0);
                a = pc_pool[$urandom_range(0, POOL_N - 1)];
                fb_pc[l] = a[31:1];
                fb_act[l] = ($urandom_range(0, 5) == 0) ? val_pool[$urandom_range(0, 3)] : val_pool[3];
            end
            tick();
        end

        rst_n = 1'b1;
        clear_inputs();
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vp_lvp_core.md
Name: vp_lvp_core

Overview:
- Parametrised last-value predictor (LVP) core. It is the successor to the fixed 2-lane baseline predictor behind the value-predictor wrapper.
- Lane count, table depth, tag width, value width and confidence width are all parameters.
- Adds tagged lookup, an internal hit/match check on feedback, a confidence threshold output, pipeline flush, and deterministic same-cycle collision resolution.
- Sits between the Align stage (lookup) and the writeback/feedback path. Predictions are delivered at D (confidence) and E1 (value).

Parameters:
- P_NUM_PRED, 2, number of lookup and feedback lanes; lane index order equals program order.
- P_ENTRIES, 256, number of table entries; power of 2, at least 2.
- P_TAG_WIDTH, 8, partial PC tag bits per entry.
- P_VALUE_WIDTH, 32, width of the predicted value.
- P_CONF_WIDTH, 3, width of the saturating confidence counter.
- P_CONF_THRES, 7, confident when conf >= P_CONF_THRES; must be <= 2^P_CONF_WIDTH-1.

Ports:
- clk_i, in, 1, main clock.
- rst_ni, in, 1, reset: synchronous, active-low.
- fw_pc_aln_i, in, [P_NUM_PRED][31:1], lookup PC per lane (Align stage).
- fw_valid_aln_i, in, [P_NUM_PRED], lookup qualifier per lane.
- flush_i, in, 1, kills all in-flight predictions.
- pred_conf_d_o, out, [P_NUM_PRED][P_CONF_WIDTH-1:0], confidence of the hit entry; 0 on a miss.
- pred_confident_d_o, out, [P_NUM_PRED], hit AND conf >= P_CONF_THRES.
- pred_valid_d_o, out, [P_NUM_PRED], fw_valid_aln_i delayed by 1 cycle.
- pred_result_e1_o, out, [P_NUM_PRED][P_VALUE_WIDTH-1:0], predicted value; 0 on a miss.
- pred_valid_e1_o, out, [P_NUM_PRED], pred_valid_d_o delayed by 1 cycle.
- fb_pc_i, in, [P_NUM_PRED][31:1], PC of the retired instruction.
- fb_actual_i, in, [P_NUM_PRED][P_VALUE_WIDTH-1:0], actual result.
- fb_valid_i, in, [P_NUM_PRED], feedback qualifier.

Behaviour:
- Address mapping:
  - IDX_W = log2(P_ENTRIES).
  - index = pc[IDX_W:1].
  - tag = pc[IDX_W+P_TAG_WIDTH:IDX_W+1].
- Entry contents: {valid, tag, value, conf}. The table is held in flops.
- Reset (rst_ni=0 at a clk_i edge):
  - All entry valid bits are cleared.
  - All outputs are 0 on the following cycle.
  - Reset mid-pipeline drops every in-flight prediction.
- Lookup (cycle N, lane i valid):
  - The entry is read combinationally.
  - hit = valid AND tag match.
  - At N+1: pred_valid_d_o[i]=1, pred_conf_d_o, pred_confident_d_o.
  - At N+2: pred_result_e1_o[i]=value and pred_valid_e1_o[i]=1.
  - Throughput: 1 lookup per lane per cycle. There are no stalls.
- Invalid lookup lane: its valid output is 0 and its conf/confident outputs are 0. The result register for that lane still loads 0.
- flush_i=1 in cycle N:
  - The D and E1 valid registers load 0 at the N edge.
  - The lookup presented in cycle N is also dropped.
  - The table is not affected.
- Feedback (cycle N, lane j valid), written at the end of cycle N:
  - Hit and actual == stored value: conf saturating increment (stays at 2^P_CONF_WIDTH-1).
  - Hit and actual != stored value: value <= actual, conf <= 0.
  - Miss (invalid or tag mismatch): allocate; valid=1, tag, value=actual, conf=0. This overwrites unconditionally (direct-mapped).
- Feedback collision: when several valid lanes target the same index in one cycle, only the highest-numbered lane is applied. The lower lanes are discarded, with no merging.
- Read during write: a lookup in the same cycle as a feedback write to the same index sees the pre-update contents. There is no bypass.
- Width rules:
  - Confidence arithmetic is unsigned, P_CONF_WIDTH bits, and saturating.
  - The tag compare is exact.

Decomposition:
- Package vp_lvp_pkg holds:
  - The entry struct typedef {valid, tag, value, conf}, parametrised via localparams.
  - Functions get_index(pc) and get_tag(pc).
  - A saturating-increment function.
- One sub-module, vp_lvp_fb_arb: per-lane feedback collision masking. It is a combinational priority by index equality, producing a write-enable per lane.
- The table and pipeline registers stay in vp_lvp_core.

Test Plan:
- Reset, then lookup PC 0x100 on lane 0:
  - N+1: pred_valid_d_o=01, conf=0, confident=0.
  - N+2: pred_result_e1_o[0]=0.
- Training with default parameters:
  - Feedback PC 0x100, value 0xDEADBEEF, repeated 8 times.
  - Conf reaches 7.
  - A later lookup gives confident=1 at D and result 0xDEADBEEF at E1.
  - A 9th identical feedback leaves conf at 7.
- Trained entry, then feedback value 0x1: a later lookup gives conf=0, confident=0, result 0x1.
- Collision: same cycle, lane 0 PC 0x200 value 0xA and lane 1 PC 0x200 value 0xB → the entry holds 0xB with conf=0.
- Aliasing: PCs differing only in tag bits (0x100 vs 0x100+2^(IDX_W+1)) → the second allocation evicts the first, and the first PC then misses.
- Flush and reset:
  - flush_i asserted the cycle after a valid lookup → pred_valid_e1_o=0 and pred_valid_d_o=0 next cycle; table contents are retained.
  - rst_ni low for 1 cycle mid-stream → all outputs 0 and the table is empty.
